ws2812_rx: RTL

Single-wire WS2812 stream receiver: decodes the NRZ pulse-width protocol driven by the LED-matrix transmitter back into 24-bit pixel words. It sits on a spare input pin for loopback checking of the matrix driver, and as a front end for a daisy-chained tap. Each decoded pixel is presented as a `color_t` with its index and a one-cycle valid strobe. Latch gaps are reported as frame boundaries, and malformed pulses are flagged.

---
 rtl/ws2812_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: pulse-width decoding into {red, green, blue} pixel words with frame and error strobes.
// Daisy-chain forwarding of the line after NUM_LEDS words is enabled by defining WS2812_RX_PASSTHRU_EN.
module ws2812_rx #(
  parameter int CLK_FREQ  = 20_000_000,
  parameter int NUM_LEDS  = 256,
  parameter int T_MIN     = int'(longint'(CLK_FREQ) * 2 / 10_000_000),
  parameter int T_THR     = int'(longint'(CLK_FREQ) * 6 / 10_000_000),
  parameter int T_MAX     = int'(longint'(CLK_FREQ) * 12 / 10_000_000),
  parameter int LATCH_DET = int'(longint'(CLK_FREQ) * 50 / 1_000_000)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            i_in,
  output logic                            o_valid,
  output logic [23:0]                     o_color,
  output logic [8:0]                      o_led_idx,
  output logic                            o_frame_done,
  output logic [$clog2(NUM_LEDS+1)-1:0]   o_led_count,
  output logic                            o_err,
  output logic                            o_busy,
  output logic                            o_out
);
  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam int HW = ($clog2(T_MAX + 2) < 5) ? 5 : $clog2(T_MAX + 2);
  localparam logic [HW-1:0] MIN_W   = HW'(T_MIN);
  localparam logic [HW-1:0] THR_W   = HW'(T_THR);
  localparam logic [HW-1:0] MAX_W   = HW'(T_MAX);
  localparam logic [17:0]   LATCH_W = 18'(LATCH_DET);
  localparam logic [LW-1:0] NUM_W   = LW'(NUM_LEDS);

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } color_t;

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t          state, state_nx;
  logic            sync1, in_s, in_d;
  logic [HW-1:0]   high_ctr, high_nx;
  logic [17:0]     low_ctr, low_nx;
  logic [4:0]      bit_cnt, bit_nx;
  logic [LW-1:0]   led_idx, idx_nx, count_nx;
  logic [23:0]     shreg, shreg_nx, shifted;
  logic [8:0]      lidx_nx;
  color_t          color_nx;
  logic            valid_nx, done_nx, err_nx, out_nx;
  logic            rise, fall;

  assign rise    = in_s & ~in_d;
  assign fall    = ~in_s & in_d;
  assign shifted = {shreg[22:0], (high_ctr >= THR_W)};
  assign o_busy  = (state != SYNC) && ((led_idx != '0) || (bit_cnt != '0) || (state == HIGH));

  always_comb begin
    state_nx = state;
    high_nx  = high_ctr;
    low_nx   = low_ctr;
    bit_nx   = bit_cnt;
    idx_nx   = led_idx;
    shreg_nx = shreg;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    color_nx = o_color;
    lidx_nx  = o_led_idx;
    count_nx = o_led_count;
    case (state)
      SYNC: begin
        if (in_s) begin
          low_nx = '0;
        end else if (low_ctr == LATCH_W) begin
          state_nx = LOW;
          bit_nx   = '0;
          idx_nx   = '0;
          shreg_nx = '0;
        end else begin
          low_nx = low_ctr + 18'd1;
        end
      end
      LOW: begin
        if (rise) begin
          state_nx = HIGH;
          high_nx  = HW'(1);
          low_nx   = '0;
        end else if (low_ctr != LATCH_W) begin
          low_nx = low_ctr + 18'd1;
        end else if ((led_idx != '0) || (bit_cnt != '0)) begin
          // Latch gap ends the frame; a half-received word is also an error.
          done_nx  = 1'b1;
          count_nx = led_idx;
          err_nx   = (bit_cnt != '0);
          bit_nx   = '0;
          idx_nx   = '0;
          shreg_nx = '0;
        end
      end
      HIGH: begin
        if (high_ctr > MAX_W) begin
          err_nx   = 1'b1;
          state_nx = SYNC;
          low_nx   = '0;
        end else if (fall) begin
          if (high_ctr < MIN_W) begin
            err_nx   = 1'b1;
            state_nx = SYNC;
            low_nx   = '0;
          end else begin
            state_nx = LOW;
            shreg_nx = shifted;
            if (bit_cnt == 5'd23) begin
              bit_nx = '0;
              if (led_idx < NUM_W) begin
                valid_nx       = 1'b1;
                color_nx.green = shifted[23:16];
                color_nx.red   = shifted[15:8];
                color_nx.blue  = shifted[7:0];
                lidx_nx        = 9'(led_idx);
                idx_nx         = led_idx + 1'b1;
              end
            end else begin
              bit_nx = bit_cnt + 5'd1;
            end
          end
        end else if (high_ctr != '1) begin
          high_nx = high_ctr + 1'b1;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

`ifdef WS2812_RX_PASSTHRU_EN
  // Next-state terms so forwarding drops in the same cycle as a frame end or error.
  assign out_nx = (state_nx != SYNC) && (idx_nx == NUM_W) && in_s;
`else
  assign out_nx = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SYNC;
      sync1        <= 1'b0;
      in_s         <= 1'b0;
      in_d         <= 1'b0;
      high_ctr     <= '0;
      low_ctr      <= '0;
      bit_cnt      <= '0;
      led_idx      <= '0;
      shreg        <= '0;
      o_valid      <= 1'b0;
      o_color      <= '0;
      o_led_idx    <= '0;
      o_frame_done <= 1'b0;
      o_led_count  <= '0;
      o_err        <= 1'b0;
      o_out        <= 1'b0;
    end else begin
      sync1        <= i_in;
      in_s         <= sync1;
      in_d         <= in_s;
      state        <= state_nx;
      high_ctr     <= high_nx;
      low_ctr      <= low_nx;
      bit_cnt      <= bit_nx;
      led_idx      <= idx_nx;
      shreg        <= shreg_nx;
      o_valid      <= valid_nx;
      o_color      <= color_nx;
      o_led_idx    <= lidx_nx;
      o_frame_done <= done_nx;
      o_led_count  <= count_nx;
      o_err        <= err_nx;
      o_out        <= out_nx;
    end
  end
endmodule
